// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory-access stage of the 5-stage pipeline. Performs the
//                data-memory load/store over a req/ack bus, selects the
//                writeback value and registers it into the MEM/WB outputs.
//                Drives stall to freeze upstream registers while a bus access
//                is outstanding.
//                Optional sub-word accesses are enabled by defining the
//                macro MEM_SUBWORD_EN; without it every access is a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int MAX_WAIT = 0          // REQ cycles before abort, 0 = wait forever (max 256)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  control_in,
    input  logic [31:0] pc_4_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] sw_in,
    input  logic [4:0]  regdst_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [4:0]  wb_regdst,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_timeout;
    logic [31:0] r_load_data;
    logic        r_dmem_req;
    logic        r_dmem_we;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;
    logic [3:0]  r_dmem_be;
    logic        r_wb_valid;
    logic        r_wb_regwrite;
    logic [4:0]  r_wb_regdst;
    logic [31:0] r_wb_data;
    logic        r_mem_err;

    // Control word decode
    logic w_bubble, w_mem_read, w_mem_write, w_reg_write, w_mem_to_reg, w_link;
    logic w_memop;
    assign w_bubble     = control_in[0];
    assign w_mem_read   = control_in[1];
    assign w_mem_write  = control_in[2];
    assign w_reg_write  = control_in[3];
    assign w_mem_to_reg = control_in[4];
    assign w_link       = control_in[5];
    assign w_memop      = !w_bubble && (w_mem_read || w_mem_write);

    // Bus-side values for the access about to be launched, and the
    // lane-extracted load value for the access in flight
    logic        w_misaligned;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_load_ext;

`ifdef MEM_SUBWORD_EN
    logic [31:0] w_rd_shifted;
    logic [15:0] w_rd_half;
    assign w_rd_shifted = dmem_rdata >> {r_dmem_addr[1:0], 3'b000};
    assign w_rd_half    = r_dmem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    // Sub-word address check, byte enables and store-lane replication
    always_comb begin
        w_misaligned = 1'b0;
        w_addr       = alu_in;
        w_be         = 4'hF;
        w_wdata      = sw_in;
        case (control_in[7:6])
            2'b00: begin
                w_misaligned = (alu_in[1:0] != 2'b00);
            end
            2'b01: begin
                w_misaligned = alu_in[0];
                w_be         = alu_in[1] ? 4'hC : 4'h3;
                w_wdata      = {2{sw_in[15:0]}};
            end
            default: begin
                w_be         = 4'b0001 << alu_in[1:0];
                w_wdata      = {4{sw_in[7:0]}};
            end
        endcase
    end

    // Load lane selection with sign/zero extension by access size
    always_comb begin
        w_load_ext = dmem_rdata;
        case (control_in[7:6])
            2'b00:   w_load_ext = dmem_rdata;
            2'b01:   w_load_ext = {{16{w_rd_half[15]}}, w_rd_half};
            2'b10:   w_load_ext = {{24{w_rd_shifted[7]}}, w_rd_shifted[7:0]};
            default: w_load_ext = {24'h000000, w_rd_shifted[7:0]};
        endcase
    end
`else
    // Word-only bus: the size field has no meaning here
    logic w_unused_size;
    assign w_unused_size = &{1'b0, control_in[7:6]};
    assign w_misaligned  = 1'b0;
    assign w_addr        = {alu_in[31:2], 2'b00};
    assign w_be          = 4'hF;
    assign w_wdata       = sw_in;
    assign w_load_ext    = dmem_rdata;
`endif

    logic w_bad_access;
    logic w_launch;
    logic [31:0] w_wb_value;
    assign w_bad_access = w_memop && w_misaligned;
    assign w_launch     = w_memop && !w_misaligned;
    assign w_wb_value   = w_link ? pc_4_in : (w_mem_to_reg ? r_load_data : alu_in);

    // Stall covers the launch cycle and every REQ cycle; reset drops it at once
    assign stall = !reset && ((r_state == S_REQ) || ((r_state == S_IDLE) && w_launch));

    // Access sequencer plus the MEM/WB register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 8'd0;
            r_timeout     <= 1'b0;
            r_load_data   <= 32'd0;
            r_dmem_req    <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_dmem_addr   <= 32'd0;
            r_dmem_wdata  <= 32'd0;
            r_dmem_be     <= 4'd0;
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_regdst   <= 5'd0;
            r_wb_data     <= 32'd0;
            r_mem_err     <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_dmem_req    <= 1'b1;
                        r_dmem_we     <= w_mem_write;
                        r_dmem_addr   <= w_addr;
                        r_dmem_wdata  <= w_wdata;
                        r_dmem_be     <= w_be;
                        r_wait_cnt    <= 8'd0;
                        r_timeout     <= 1'b0;
                        // MEM/WB carries a bubble while the access is in flight
                        r_wb_valid    <= 1'b0;
                        r_wb_regwrite <= 1'b0;
                        r_state       <= S_REQ;
                    end else begin
                        r_wb_valid    <= !w_bubble;
                        r_wb_regwrite <= w_reg_write && !w_bubble && !w_bad_access;
                        r_wb_regdst   <= regdst_in;
                        r_wb_data     <= w_wb_value;
                        r_mem_err     <= w_bad_access;
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        r_load_data <= w_load_ext;
                        r_dmem_req  <= 1'b0;
                        r_state     <= S_DONE;
                    end else if ((MAX_WAIT != 0) && (r_wait_cnt == 8'(MAX_WAIT - 1))) begin
                        r_dmem_req  <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_mem_err   <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    // EX/MEM was frozen, so control_in still describes this access
                    r_wb_valid    <= !w_bubble;
                    r_wb_regwrite <= w_reg_write && !w_bubble && !r_timeout;
                    r_wb_regdst   <= regdst_in;
                    r_wb_data     <= w_wb_value;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem_req    = r_dmem_req;
    assign dmem_we     = r_dmem_we;
    assign dmem_addr   = r_dmem_addr;
    assign dmem_wdata  = r_dmem_wdata;
    assign dmem_be     = r_dmem_be;
    assign wb_valid    = r_wb_valid;
    assign wb_regwrite = r_wb_regwrite;
    assign wb_regdst   = r_wb_regdst;
    assign wb_data     = r_wb_data;
    assign mem_err     = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Self-checking bench for mem_wb_stage: directed cases plus
//                randomized instructions against a transaction-level model.
//                Define MEM_SUBWORD_EN to exercise the sub-word build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int MAXW = 4;
`ifdef MEM_SUBWORD_EN
    localparam bit SUBW = 1'b1;
`else
    localparam bit SUBW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  control_in;
    logic [31:0] pc_4_in, alu_in, sw_in;
    logic [4:0]  regdst_in;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_regdst;
    logic [31:0] wb_data;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .control_in (control_in),
        .pc_4_in    (pc_4_in),
        .alu_in     (alu_in),
        .sw_in      (sw_in),
        .regdst_in  (regdst_in),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_regwrite(wb_regwrite),
        .wb_regdst  (wb_regdst),
        .wb_data    (wb_data),
        .mem_err    (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one instruction at posedge+1 and follow it until MEM/WB loads.
    // ack_dly = REQ cycles before ack (0 = ack in first REQ cycle).
    task automatic run_instr(input string tag, input logic [7:0] ctrl, input logic [31:0] pc4,
                             input logic [31:0] alu, input logic [31:0] sw, input logic [4:0] rd,
                             input int ack_dly, input logic [31:0] rdata);
        bit bub, rdop, wrop, rw, m2r, lnk, memop, mis, to, chk_data, done;
        int sz, lane, hsel, exp_stall, ack_at, n_stall, n_req, v;
        logic [31:0] e_addr, e_wdata, e_load, e_data;
        logic [3:0]  e_be;
        logic        s_stall;

        // ---- reference model ----
        bub  = ctrl[0]; rdop = ctrl[1]; wrop = ctrl[2];
        rw   = ctrl[3]; m2r  = ctrl[4]; lnk  = ctrl[5];
        sz   = SUBW ? int'(ctrl[7:6]) : 0;
        lane = int'(alu & 32'h3);
        hsel = lane / 2;
        memop = !bub && (rdop || wrop);
        mis   = memop && SUBW && ((sz == 0 && lane != 0) || (sz == 1 && (lane % 2) != 0));
        to    = memop && !mis && (ack_dly >= MAXW);
        exp_stall = (!memop || mis) ? 0 : (to ? 1 + MAXW : 2 + ack_dly);
        e_addr = SUBW ? alu : (alu & ~32'h3);
        case (sz)
            0: begin e_be = 4'hF; e_wdata = sw; e_load = rdata; end
            1: begin
                e_be    = 4'(3 << (2 * hsel));
                e_wdata = (sw & 32'hFFFF) * 32'h0001_0001;
                v = int'((rdata >> (16 * hsel)) & 32'hFFFF);
                if (v >= 32768) v -= 65536;
                e_load = 32'(v);
            end
            default: begin
                e_be    = 4'(1 << lane);
                e_wdata = (sw & 32'hFF) * 32'h0101_0101;
                v = int'((rdata >> (8 * lane)) & 32'hFF);
                if (sz == 2 && v >= 128) v -= 256;
                e_load = 32'(v);
            end
        endcase
        e_data   = lnk ? pc4 : (m2r ? e_load : alu);
        chk_data = lnk || !m2r || (memop && !mis && !to);

        // ---- stimulus ----
        control_in = ctrl; pc_4_in = pc4; alu_in = alu; sw_in = sw; regdst_in = rd;
        dmem_rdata = rdata;
        ack_at  = memop ? 1 + ack_dly : 0;
        n_stall = 0; n_req = 0; done = 0; s_stall = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            dmem_ack = (k == ack_at);
            #4;
            s_stall = stall;
            if (dmem_req) n_req++;
            if (memop && !mis && k == 1) begin
                check({tag, "_req"},   {31'd0, dmem_req}, 32'd1);
                check({tag, "_we"},    {31'd0, dmem_we},  {31'd0, wrop});
                check({tag, "_addr"},  dmem_addr,  e_addr);
                check({tag, "_be"},    {28'd0, dmem_be},  {28'd0, e_be});
                check({tag, "_wdata"}, dmem_wdata, e_wdata);
            end
            if (!s_stall) begin
                done = 1;
                if (memop && !mis) begin
                    check({tag, "_done_req"}, {31'd0, dmem_req}, 32'd0);
                    check({tag, "_done_err"}, {31'd0, mem_err},  {31'd0, to});
                end
            end else begin
                n_stall++;
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        if (!done) begin
            check({tag, "_stall_stuck"}, {31'd0, s_stall}, 32'd0);
            reset = 1'b1; #1; reset = 1'b0;
            return;
        end
        check({tag, "_stall_cyc"}, n_stall, exp_stall);
        check({tag, "_req_cyc"},   n_req, (exp_stall > 0) ? exp_stall - 1 : 0);
        check({tag, "_wb_valid"},  {31'd0, wb_valid},    {31'd0, !bub});
        check({tag, "_wb_rw"},     {31'd0, wb_regwrite}, {31'd0, rw && !bub && !mis && !to});
        check({tag, "_wb_rd"},     {27'd0, wb_regdst},   {27'd0, rd});
        if (chk_data) check({tag, "_wb_data"}, wb_data, e_data);
        check({tag, "_err_after"}, {31'd0, mem_err}, {31'd0, mis});
    endtask

    initial begin
        logic [7:0] ctrl;
        int kind, dly;
        reset = 1'b1; control_in = 8'h01; pc_4_in = '0; alu_in = '0; sw_in = '0;
        regdst_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, stall},       32'd0);
        check("rst_req",   {31'd0, dmem_req},    32'd0);
        check("rst_we",    {31'd0, dmem_we},     32'd0);
        check("rst_addr",  dmem_addr,            32'd0);
        check("rst_wdata", dmem_wdata,           32'd0);
        check("rst_be",    {28'd0, dmem_be},     32'd0);
        check("rst_valid", {31'd0, wb_valid},    32'd0);
        check("rst_rw",    {31'd0, wb_regwrite}, 32'd0);
        check("rst_data",  wb_data,              32'd0);
        check("rst_err",   {31'd0, mem_err},     32'd0);
        reset = 1'b0;

        // Reset in the middle of a REQ, then a stale ack
        control_in = 8'h1A; alu_in = 32'h200; regdst_in = 5'd7;
        @(posedge clk); #1;
        check("mreq_req_before", {31'd0, dmem_req}, 32'd1);
        #1 reset = 1'b1; #1;
        check("mreq_req_rst",   {31'd0, dmem_req}, 32'd0);
        check("mreq_stall_rst", {31'd0, stall},    32'd0);
        control_in = 8'h01;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1 dmem_ack = 1'b0;
        check("mreq_late_req",   {31'd0, dmem_req},    32'd0);
        check("mreq_late_stall", {31'd0, stall},       32'd0);
        check("mreq_late_rw",    {31'd0, wb_regwrite}, 32'd0);
        check("mreq_late_valid", {31'd0, wb_valid},    32'd0);
        check("mreq_late_err",   {31'd0, mem_err},     32'd0);

        // Directed cases
        run_instr("alu",  8'h08, 32'h4, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
        run_instr("lw",   8'h1A, 32'h8, 32'h100, 32'h0, 5'd9, 3, 32'hDEAD_BEEF);
        run_instr("lw0",  8'h1A, 32'h8, 32'h104, 32'h0, 5'd3, 0, 32'h0BAD_F00D);
        run_instr("link", 8'h28, 32'h44, 32'h9, 32'h0, 5'd31, 0, 32'h0);
        run_instr("tmo",  8'h1A, 32'h8, 32'h108, 32'h0, 5'd4, MAXW, 32'h1111_2222);
        run_instr("swto", 8'h0C, 32'h8, 32'h10C, 32'h7, 5'd4, 30, 32'h0);
        run_instr("swr",  8'h06, 32'h8, 32'h110, 32'hCAFE, 5'd1, 1, 32'h0);
`ifdef MEM_SUBWORD_EN
        run_instr("lb",   8'h9A, 32'h8, 32'h103, 32'h0, 5'd2, 0, 32'h8011_2233);
        run_instr("lbu",  8'hDA, 32'h8, 32'h103, 32'h0, 5'd2, 1, 32'h8011_2233);
        run_instr("sh",   8'h44, 32'h8, 32'h102, 32'hABCD, 5'd0, 0, 32'h0);
        run_instr("swmis",8'h0C, 32'h8, 32'h101, 32'h1, 5'd6, 0, 32'h0);
        run_instr("lhmis",8'h5A, 32'h8, 32'h105, 32'h0, 5'd6, 0, 32'h0);
`endif

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 3);
            ctrl = 8'($urandom);
            ctrl[4] = 1'b0;
            case (kind)
                0: begin ctrl[0] = 1'b0; ctrl[1] = 1'b0; ctrl[2] = 1'b0; end
                1: begin ctrl[0] = 1'b0; ctrl[1] = 1'b1; ctrl[2] = 1'b0; ctrl[4] = 1'b1; end
                2: begin ctrl[0] = 1'b0; ctrl[2] = 1'b1; end
                default: ctrl[0] = 1'b1;
            endcase
            ctrl[5] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) dly = $urandom_range(0, 1) ? MAXW : 30;
            else dly = $urandom_range(0, 3);
            run_instr($sformatf("rnd%0d", i), ctrl, $urandom, $urandom, $urandom,
                      5'($urandom), dly, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
